// File: rtl/fx2_fifo_scheduler.sv
// fx2_fifo_scheduler
// Round-robin owner of the FX2LP slave-FIFO bus. Two host->device endpoints
// (EP2/EP4) feed local sinks, two device->host endpoints (EP6/EP8) drain local
// sources. Each grant is one bounded burst framed by SELECT and GAP cycles.
module fx2_fifo_scheduler #(
    parameter int BURST_MAX  = 16,
    parameter int TURNAROUND = 1
) (
    input  logic        fx2_ifclk,
    input  logic        reset,
    input  logic [3:0]  fx2_flags,
    input  logic [15:0] fx2_fd_in,
    output logic [15:0] fx2_fd_out,
    output logic        fx2_fd_oe,
    output logic [1:0]  fx2_fifoaddr,
    output logic        fx2_slrd,
    output logic        fx2_slwr,
    output logic        fx2_sloe,
    output logic        fx2_pktend,
    input  logic [1:0]  rx_ready,
    output logic [15:0] rx_data,
    output logic [1:0]  rx_valid,
    input  logic [1:0]  tx_valid,
    input  logic [15:0] tx_data0,
    input  logic [15:0] tx_data1,
    input  logic [1:0]  tx_last,
    output logic [1:0]  tx_ack,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_READ,
        S_WRITE,
        S_PKTEND,
        S_GAP
    } state_t;

    state_t         r_state;
    logic [1:0]     r_grant;
    logic [1:0]     r_last;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_ta;
    logic [15:0]    r_rx_data;
    logic [1:0]     r_rx_valid;

    logic [3:0]     w_elig;
    logic           w_cur_elig;
    logic           w_any;
    logic [1:0]     w_pick;
    logic           w_do_rd;
    logic           w_do_wr;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_cnt_done;

    // Per-endpoint eligibility: FX2 side has room/data and the local side agrees.
    assign w_elig = {fx2_flags[3] & tx_valid[1],
                     fx2_flags[2] & tx_valid[0],
                     fx2_flags[1] & rx_ready[1],
                     fx2_flags[0] & rx_ready[0]};

    assign w_cur_elig = w_elig[r_grant];
    assign w_do_rd    = (r_state == S_READ)  && w_cur_elig;
    assign w_do_wr    = (r_state == S_WRITE) && w_cur_elig;

    // Saturating word counter: never wraps past BURST_MAX.
    assign w_cnt_inc  = (r_cnt == CW'(BURST_MAX)) ? r_cnt : r_cnt + 1'b1;
    assign w_cnt_done = (w_cnt_inc == CW'(BURST_MAX));

    // Round-robin pick: scanning from farthest offset down leaves last+1 winning.
    always_comb begin
        logic [1:0] idx;
        w_any  = 1'b0;
        w_pick = r_last;
        idx    = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = r_last + 2'(i);
            if (w_elig[idx]) begin
                w_any  = 1'b1;
                w_pick = idx;
            end
        end
    end

    // Burst sequencer: grant, turnaround, transfer, optional PKTEND, gap.
    always_ff @(posedge fx2_ifclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'd0;
            r_last     <= 2'd3;
            r_cnt      <= '0;
            r_ta       <= 2'd0;
            r_rx_data  <= 16'h0000;
            r_rx_valid <= 2'b00;
        end else begin
            r_rx_valid <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                        r_ta    <= 2'd0;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_ta == 2'(TURNAROUND - 1)) begin
                        r_state <= r_grant[1] ? S_WRITE : S_READ;
                    end else begin
                        r_ta <= r_ta + 2'd1;
                    end
                end
                S_READ: begin
                    if (w_cur_elig) begin
                        r_rx_data  <= fx2_fd_in;
                        r_rx_valid <= r_grant[0] ? 2'b10 : 2'b01;
                        r_cnt      <= w_cnt_inc;
                        if (w_cnt_done) begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_WRITE: begin
                    if (w_cur_elig) begin
                        r_cnt <= w_cnt_inc;
                        // A packet end outranks the burst limit.
                        if (tx_last[r_grant[0]]) begin
                            r_state <= S_PKTEND;
                        end else if (w_cnt_done) begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_PKTEND: begin
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pin and handshake decode; strobes follow eligibility within the cycle.
    assign fx2_slrd     = ~w_do_rd;
    assign fx2_slwr     = ~w_do_wr;
    assign tx_ack       = w_do_wr ? (r_grant[0] ? 2'b10 : 2'b01) : 2'b00;
    assign fx2_pktend   = ~(r_state == S_PKTEND);
    assign fx2_sloe     = ~(((r_state == S_SELECT) || (r_state == S_READ)) && !r_grant[1]);
    assign fx2_fd_oe    = ((r_state == S_SELECT) || (r_state == S_WRITE) ||
                           (r_state == S_PKTEND)) && r_grant[1];
    assign fx2_fd_out   = (r_state == S_WRITE) ? (r_grant[0] ? tx_data1 : tx_data0) : 16'h0000;
    assign fx2_fifoaddr = r_grant;
    assign grant        = r_grant;
    assign busy         = (r_state != S_IDLE);
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;

endmodule
